// File: rtl/healthy_vec_scan_ctrl_pkg.sv
// ============================================================================
// Module : healthy_vec_scan_ctrl_pkg
// Brief  : Shared widths and scan FSM encodings for the reference-vector ROMs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package healthy_vec_scan_ctrl_pkg;

    localparam int DEF_RAM_WIDTH  = 4;
    localparam int DEF_ADDR_BITS  = 6;
    localparam int DEF_VEC_LEN    = 64;
    localparam int DEF_FEAT_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/healthy_vec_scan_ctrl_vec_mac_acc.sv
// ============================================================================
// Module : vec_mac_acc
// Brief  : Unsigned multiply-accumulate register with synchronous clear/enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vec_mac_acc
    import healthy_vec_scan_ctrl_pkg::*;
#(
    parameter int A_WIDTH   = DEF_FEAT_WIDTH,
    parameter int B_WIDTH   = DEF_RAM_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] sum
);

    logic [ACC_WIDTH-1:0] product;

    // Accumulator is sized so the running sum can never wrap.
    assign product = ACC_WIDTH'(a) * ACC_WIDTH'(b);
    assign sum     = acc + product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

`default_nettype wire

// File: rtl/healthy_vec_scan_ctrl.sv
// ============================================================================
// Module : healthy_vec_scan_ctrl
// Brief  : Walks the healthy-reference ROM in lockstep with the feature stream
//          and emits one dot-product similarity score per scan.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module healthy_vec_scan_ctrl
    import healthy_vec_scan_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int VEC_LEN    = DEF_VEC_LEN,
    parameter int FEAT_WIDTH = DEF_FEAT_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  feat_valid,
    input  logic [FEAT_WIDTH-1:0] feat_data,
    output logic                  feat_ready,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [RAM_WIDTH-1:0]  rom_data,
    output logic                  busy,
    output logic                  score_valid,
    output logic [ACC_WIDTH-1:0]  score
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(VEC_LEN - 1);

    scan_state_t          state;
    scan_state_t          next_state;
    logic [ADDR_BITS-1:0] idx;
    logic [ACC_WIDTH-1:0] mac_acc;
    logic [ACC_WIDTH-1:0] mac_sum;
    logic                 beat;
    logic                 last_beat;
    logic                 mac_clear;
    logic                 mac_en;
    logic                 idx_clear;
    logic                 idx_inc;
    logic                 score_load;

    assign beat      = feat_valid & feat_ready;
    assign last_beat = beat & (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        idx_clear  = 1'b0;
        idx_inc    = 1'b0;
        score_load = 1'b0;
        case (state)
            IDLE: begin
                // start takes priority over a simultaneous abort here
                if (start) begin
                    next_state = RUN;
                    mac_clear  = 1'b1;
                    idx_clear  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                    mac_clear  = 1'b1;
                    idx_clear  = 1'b1;
                end else if (last_beat) begin
                    next_state = DONE;
                    mac_en     = 1'b1;
                    idx_clear  = 1'b1;
                    score_load = 1'b1;
                end else if (beat) begin
                    mac_en  = 1'b1;
                    idx_inc = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            score <= '0;
        end else begin
            if (idx_clear) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + ADDR_BITS'(1);
            end
            if (score_load) begin
                score <= mac_sum;
            end
        end
    end

    vec_mac_acc #(
        .A_WIDTH   (FEAT_WIDTH),
        .B_WIDTH   (RAM_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (feat_data),
        .b     (rom_data),
        .acc   (mac_acc),
        .sum   (mac_sum)
    );

    assign rom_addr    = idx;
    assign feat_ready  = (state == RUN);
    assign busy        = (state == RUN);
    assign score_valid = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_healthy_vec_scan_ctrl.sv
// ============================================================================
// Module : tb_healthy_vec_scan_ctrl
// Brief  : Directed self-checking bench for healthy_vec_scan_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_healthy_vec_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        feat_valid = 1'b0;
    logic [7:0]  feat_data = '0;
    logic        feat_ready;
    logic [5:0]  rom_addr;
    logic [3:0]  rom_data;
    logic        busy;
    logic        score_valid;
    logic [17:0] score;

    logic [3:0]  rom_mem  [64];
    logic [7:0]  feat_mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr];

    healthy_vec_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .feat_valid  (feat_valid),
        .feat_data   (feat_data),
        .feat_ready  (feat_ready),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .busy        (busy),
        .score_valid (score_valid),
        .score       (score)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int rom_mode, input int feat_mode);
        for (int i = 0; i < 64; i++) begin
            case (rom_mode)
                0: rom_mem[i] = 4'd1;
                1: rom_mem[i] = 4'd15;
                default: rom_mem[i] = 4'(i % 16);
            endcase
            case (feat_mode)
                0: feat_mem[i] = 8'd1;
                1: feat_mem[i] = 8'd255;
                2: feat_mem[i] = 8'(i % 4);
                default: feat_mem[i] = 8'd2;
            endcase
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic run_scan(input bit toggle, input int abort_after, input bit start_mid,
                            input bit abort_with_start,
                            output int busy_cnt, output int sv_cnt, output int sv_edge,
                            output int sv_beats);
        int  beats;
        bit  beat;
        beats    = 0;
        busy_cnt = 0;
        sv_cnt   = 0;
        sv_edge  = -1;
        sv_beats = -1;
        start      = 1'b1;
        abort      = abort_with_start;
        feat_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (busy) busy_cnt++;
        for (int e = 1; e <= 160; e++) begin
            feat_valid = toggle ? e[0] : 1'b1;
            feat_data  = feat_mem[beats % 64];
            abort      = (abort_after >= 0) && (beats == abort_after) && busy;
            start      = start_mid && (e == 10);
            beat       = feat_valid && feat_ready;
            @(posedge clk);
            #1;
            if (beat) beats++;
            if (busy) busy_cnt++;
            if (score_valid) begin
                sv_cnt++;
                sv_edge  = e;
                sv_beats = beats;
            end
        end
        start      = 1'b0;
        abort      = 1'b0;
        feat_valid = 1'b0;
    endtask

    initial begin
        int bc, sc, se, sb;
        load(0, 0);
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(feat_ready), 32'd0);
        check("reset_score", 32'(score), 32'd0);
        check("reset_addr", 32'(rom_addr), 32'd0);
        check("reset_sv", 32'(score_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ones x ones, gapless
        run_scan(1'b0, -1, 1'b0, 1'b0, bc, sc, se, sb);
        check("ones_score", 32'(score), 32'd64);
        check("ones_sv_cnt", 32'(sc), 32'd1);
        check("ones_sv_edge", 32'(se), 32'd64);
        check("ones_busy_cycles", 32'(bc), 32'd64);

        // max values, overflow boundary
        load(1, 1);
        run_scan(1'b0, -1, 1'b0, 1'b0, bc, sc, se, sb);
        check("max_score", 32'(score), 32'd244800);
        check("max_sv_cnt", 32'(sc), 32'd1);

        // ramp ROM, toggling valid
        load(2, 0);
        run_scan(1'b1, -1, 1'b0, 1'b0, bc, sc, se, sb);
        check("ramp_score", 32'(score), 32'd480);
        check("ramp_sv_cnt", 32'(sc), 32'd1);
        check("ramp_sv_beats", 32'(sb), 32'd64);
        check("ramp_sv_edge", 32'(se), 32'd127);

        // abort after 20 beats
        load(0, 0);
        run_scan(1'b0, 20, 1'b0, 1'b0, bc, sc, se, sb);
        check("abort_sv_cnt", 32'(sc), 32'd0);
        check("abort_score_held", 32'(score), 32'd480);
        check("abort_busy_cycles", 32'(bc), 32'd21);
        run_scan(1'b0, -1, 1'b0, 1'b0, bc, sc, se, sb);
        check("post_abort_score", 32'(score), 32'd64);

        // abort coincident with the last beat
        load(1, 1);
        run_scan(1'b0, 63, 1'b0, 1'b0, bc, sc, se, sb);
        check("abort_last_sv_cnt", 32'(sc), 32'd0);
        check("abort_last_score", 32'(score), 32'd64);

        // start during RUN ignored; start+abort in IDLE -> start wins
        load(2, 2);
        run_scan(1'b0, -1, 1'b1, 1'b1, bc, sc, se, sb);
        check("restart_score", 32'(score), 32'd800);
        check("restart_sv_cnt", 32'(sc), 32'd1);
        check("restart_sv_edge", 32'(se), 32'd64);
        check("restart_busy_cycles", 32'(bc), 32'd64);

        // async reset mid-scan at beat 30
        load(0, 3);
        start      = 1'b1;
        feat_valid = 1'b1;
        feat_data  = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        check("pre_rst_addr", 32'(rom_addr), 32'd30);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(feat_ready), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_sv", 32'(score_valid), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_scan(1'b0, -1, 1'b0, 1'b0, bc, sc, se, sb);
        check("post_rst_score", 32'(score), 32'd128);
        check("post_rst_sv_cnt", 32'(sc), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
